decoder_nto2n_seq: RTL

- Parametrised, registered N-to-2^N one-hot decoder with valid/ready input handshake and a self-running scan mode.
- Generalises the fixed 3-to-8 combinational decoder to any N.
- Direct mode decodes an accepted select code; scan mode walks the active output through every index with a programmable dwell time.
- Drives row/column strobes, chip selects and LED/digit scanners in the team's designs.

---
 rtl/decoder_nto2n_seq_pkg.sv | 32 +++
 rtl/decoder_nto2n_seq_hold_counter.sv | 31 +++
 rtl/decoder_nto2n_seq.sv | 132 +++++++++++++
 3 files changed

// File: rtl/decoder_nto2n_seq_pkg.sv
// decoder_pkg: shared types and helpers for the
// registered N-to-2^N decoder.
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DIRECT,
    SCAN
  } state_t;

  // Widest select code the helpers support.
  localparam int unsigned MAX_N = 8;
  localparam int unsigned MAX_W = 1 << MAX_N;

  function automatic int unsigned out_width(
    input int unsigned n
  );
    return 1 << n;
  endfunction

  // Callers size-cast the result to their
  // own output width.
  function automatic logic [MAX_W-1:0] onehot(
    input int unsigned sel
  );
    logic [MAX_W-1:0] v;
    v = '0;
    v[sel[MAX_N-1:0]] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/decoder_nto2n_seq_hold_counter.sv
// hold_counter: dwell timer for scan mode.
// Ports: clk, rst (async high), clr (sync clear),
//   en (count), tick (last dwell cycle of an index).
module hold_counter #(
  parameter int HOLD = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(HOLD + 1);
  localparam logic [CW-1:0] LAST = CW'(HOLD - 1);

  logic [CW-1:0] cnt;

  assign tick = en & ~clr & (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/decoder_nto2n_seq.sv
// decoder_nto2n_seq: registered N-to-2^N one-hot
// decoder with valid/ready input and scan mode.
// Ports: clk, rst (async high), en, mode (0 direct,
//   1 scan), in_valid/in_sel/in_ready (select input),
//   d (one-hot), idx, out_valid, wrap (scan wrap).
// Macro DECODER_ACTIVE_LOW_EN: d driven active-low.
module decoder_nto2n_seq
  import decoder_pkg::*;
#(
  parameter int N    = 3,
  parameter int HOLD = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              mode,
  input  logic              in_valid,
  input  logic [N-1:0]      in_sel,
  output logic              in_ready,
  output logic [(1<<N)-1:0] d,
  output logic [N-1:0]      idx,
  output logic              out_valid,
  output logic              wrap
);

  localparam int W = out_width(N);

  state_t         state_q, state_d;
  logic [W-1:0]   d_q, d_n;
  logic [N-1:0]   idx_q, idx_n, idx_inc;
  logic           ov_q, ov_n;
  logic           wrap_q, wrap_n;
  logic           accept;
  logic           entering;
  logic           cnt_clr;
  logic           cnt_en;
  logic           tick;

  assign in_ready = en & ~mode;
  assign accept   = in_valid & in_ready;
  assign idx_inc  = idx_q + N'(1);
  assign entering = (state_q != state_d);

  // Dwell restarts on every scan entry.
  assign cnt_clr = (state_d != SCAN) | entering;
  assign cnt_en  = (state_q == SCAN);

  hold_counter #(
    .HOLD (HOLD)
  ) u_hold (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      ~en:        state_d = IDLE;
      en & mode:  state_d = SCAN;
      en & ~mode: state_d = DIRECT;
      default:    state_d = state_q;
    endcase
  end

  always_comb begin
    d_n    = d_q;
    idx_n  = idx_q;
    ov_n   = ov_q;
    wrap_n = 1'b0;
    unique case (state_d)
      IDLE: begin
        d_n  = '0;
        ov_n = 1'b0;
      end
      DIRECT: begin
        if (accept) begin
          d_n   = W'(onehot(32'(in_sel)));
          idx_n = in_sel;
          ov_n  = 1'b1;
        end else if (entering) begin
          d_n  = '0;
          ov_n = 1'b0;
        end
      end
      SCAN: begin
        if (entering) begin
          d_n   = W'(onehot(0));
          idx_n = '0;
          ov_n  = 1'b1;
        end else if (tick) begin
          d_n    = W'(onehot(32'(idx_inc)));
          idx_n  = idx_inc;
          ov_n   = 1'b1;
          wrap_n = &idx_q;
        end
      end
      default: begin
        d_n  = '0;
        ov_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      d_q     <= '0;
      idx_q   <= '0;
      ov_q    <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_n;
      idx_q   <= idx_n;
      ov_q    <= ov_n;
      wrap_q  <= wrap_n;
    end
  end

`ifdef DECODER_ACTIVE_LOW_EN
  assign d = ~d_q;
`else
  assign d = d_q;
`endif
  assign idx       = idx_q;
  assign out_valid = ov_q;
  assign wrap      = wrap_q;

endmodule
